// File: rtl/uart_fifo_bridge_pkg.sv
// Shared constants for the UART FIFO bridge: bus addresses, status bit
// positions and transfer FSM state encodings.
package uart_fifo_bridge_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_NOT_FULL  = 1;
  localparam int ST_BREAK        = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_TX_IDLE      = 4;
  localparam int ST_TX_OVF       = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RX_RD  = 2'd1,
    S_TX_WR  = 2'd2,
    S_SETTLE = 2'd3
  } xfer_state_e;

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Single-clock FIFO with combinational head output. A pop of an empty FIFO is
// ignored; a push to a full FIFO is accepted only when a pop happens alongside.
module sync_fifo
  import uart_fifo_bridge_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Processor-side UART front end: RX/TX FIFOs, CPU data/status decode and the
// transfer FSM that strobes the UART hold registers.
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CPU_CS,
  input  logic       CPU_WE,
  input  logic       CPU_ADDR,
  input  logic [7:0] CPU_DI,
  output logic [7:0] CPU_DO,
  output logic       U_CS,
  output logic       U_WE,
  output logic [7:0] U_DI,
  input  logic [7:0] U_DO,
  input  logic       U_RX_READY,
  input  logic       U_TX_EMPTY,
  input  logic       U_BREAK
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  xfer_state_e         state_q;
  logic                u_cs_q, u_we_q;
  logic [7:0]          u_di_q;
  logic                tx_ovf_q, tx_ovf_d;
  logic                cpu_wr_data, cpu_rd_data, cpu_rd_stat;
  logic                start_rx, start_tx, rx_push, tx_drop;
  logic [7:0]          rx_dout, tx_dout, status;
  logic                rx_full, rx_empty, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] rx_count, tx_count;

  assign cpu_wr_data = CPU_CS &  CPU_WE & (CPU_ADDR == ADDR_DATA);
  assign cpu_rd_data = CPU_CS & ~CPU_WE & (CPU_ADDR == ADDR_DATA);
  assign cpu_rd_stat = CPU_CS & ~CPU_WE & (CPU_ADDR == ADDR_STAT);

  // RX is checked first so a waiting received byte always wins the idle slot.
  assign start_rx = (state_q == S_IDLE) & U_RX_READY & ~rx_full;
  assign start_tx = (state_q == S_IDLE) & ~start_rx & U_TX_EMPTY & ~tx_empty;
  assign rx_push  = (state_q == S_RX_RD);
  assign tx_drop  = cpu_wr_data & tx_full & ~start_tx;
  assign tx_ovf_d = tx_drop | (tx_ovf_q & ~cpu_rd_stat);

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(CLK), .rst(RESET), .push(rx_push), .pop(cpu_rd_data), .din(U_DO),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(CLK), .rst(RESET), .push(cpu_wr_data), .pop(start_tx), .din(CPU_DI),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  always_comb begin
    status                  = '0;
    status[ST_RX_NOT_EMPTY] = (rx_count != '0);
    status[ST_TX_NOT_FULL]  = (tx_count != FULL_CNT);
    status[ST_BREAK]        = U_BREAK;
    status[ST_RX_FULL]      = (rx_count == FULL_CNT);
    status[ST_TX_IDLE]      = tx_empty & U_TX_EMPTY & (state_q == S_IDLE);
    status[ST_TX_OVF]       = tx_ovf_q;
  end

  always_comb begin
    CPU_DO = 8'h00;
    if (cpu_rd_stat)                  CPU_DO = status;
    else if (cpu_rd_data && !rx_empty) CPU_DO = rx_dout;
  end

  always_ff @(posedge CLK) begin
    if (RESET) tx_ovf_q <= 1'b0;
    else       tx_ovf_q <= tx_ovf_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      u_cs_q  <= 1'b0;
      u_we_q  <= 1'b0;
      u_di_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rx) begin
            state_q <= S_RX_RD;
            u_cs_q  <= 1'b1;
            u_we_q  <= 1'b0;
          end else if (start_tx) begin
            state_q <= S_TX_WR;
            u_cs_q  <= 1'b1;
            u_we_q  <= 1'b1;
            u_di_q  <= tx_dout;
          end
        end
        S_RX_RD, S_TX_WR: begin
          state_q <= S_SETTLE;
          u_cs_q  <= 1'b0;
          u_we_q  <= 1'b0;
        end
        S_SETTLE: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign U_CS = u_cs_q;
  assign U_WE = u_we_q;
  assign U_DI = u_di_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge with a small UART model and
// queue scoreboards for TX strobes and RX bytes.
module tb_uart_fifo_bridge;

  logic       CLK = 1'b0;
  logic       RESET, CPU_CS, CPU_WE, CPU_ADDR;
  logic [7:0] CPU_DI, CPU_DO;
  logic       U_CS, U_WE;
  logic [7:0] U_DI;
  logic [7:0] U_DO = 8'h00;
  logic       U_RX_READY = 1'b0;
  logic       U_TX_EMPTY, U_BREAK;

  typedef struct { int cyc; logic [7:0] d; } ev_t;

  ev_t        tx_got[$], tx_exp[$];
  int         rx_got_cyc[$];
  logic [7:0] rx_src[$], rx_exp[$];
  bit         rx_en = 1'b0;
  int         cyc = 0;
  int         vectors = 0, miscompares = 0;

  uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
    .CLK(CLK), .RESET(RESET), .CPU_CS(CPU_CS), .CPU_WE(CPU_WE),
    .CPU_ADDR(CPU_ADDR), .CPU_DI(CPU_DI), .CPU_DO(CPU_DO),
    .U_CS(U_CS), .U_WE(U_WE), .U_DI(U_DI), .U_DO(U_DO),
    .U_RX_READY(U_RX_READY), .U_TX_EMPTY(U_TX_EMPTY), .U_BREAK(U_BREAK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // UART model: record strobes, consume the presented RX byte on a read strobe.
  always @(posedge CLK) begin
    if (!RESET && U_CS) begin
      if (U_WE) tx_got.push_back('{cyc, U_DI});
      else begin
        rx_got_cyc.push_back(cyc);
        if (rx_src.size() != 0) void'(rx_src.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    U_RX_READY = rx_en && (rx_src.size() != 0);
    U_DO       = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic bus(input logic we, input logic addr, input logic [7:0] di,
                     output logic [7:0] rd, output int c);
    CPU_CS = 1'b1; CPU_WE = we; CPU_ADDR = addr; CPU_DI = di;
    @(negedge CLK);
    rd = CPU_DO;
    c  = cyc;
    tick();
    CPU_CS = 1'b0; CPU_WE = 1'b0; CPU_ADDR = 1'b0; CPU_DI = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    int c;
    RESET = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    vectors++;
    if ({U_CS, U_WE, U_DI, CPU_DO} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got cs=%b we=%b di=%02h do=%02h expected all zero",
               U_CS, U_WE, U_DI, CPU_DO);
    end
    tick();
    RESET = 1'b0;
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h12) begin
      miscompares++; $display("FAIL reset_status: got %02h expected 12", rd);
    end
    // Partly fill both FIFOs, then reset on top of that.
    U_TX_EMPTY = 1'b0;
    for (int i = 0; i < 3; i++) bus(1'b1, 1'b0, 8'(8'h30 + i), rd, c);
    rx_src.push_back(8'hC0); rx_src.push_back(8'hC1); rx_en = 1'b1;
    repeat (10) tick();
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h03) begin
      miscompares++; $display("FAIL partial_fill_status: got %02h expected 03", rd);
    end
    rx_en = 1'b0; tx_got.delete(); rx_got_cyc.delete();
    RESET = 1'b1; U_TX_EMPTY = 1'b1;
    tick();
    RESET = 1'b0;
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h12) begin
      miscompares++; $display("FAIL midop_reset_status: got %02h expected 12", rd);
    end
    @(negedge CLK);
    vectors++;
    if (U_CS !== 1'b0) begin
      miscompares++; $display("FAIL midop_reset_ucs: got %b expected 0", U_CS);
    end
    tick();
    bus(1'b0, 1'b0, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++; $display("FAIL midop_reset_rxdata: got %02h expected 00", rd);
    end
    repeat (6) tick();
    vectors++;
    if (tx_got.size() != 0) begin
      miscompares++;
      $display("FAIL midop_reset_tx_discard: got %0d strobes expected 0", tx_got.size());
    end
  endtask

  task automatic test_tx_burst();
    logic [7:0] rd;
    int c, last;
    ev_t e, g;
    tx_got.delete(); tx_exp.delete();
    U_TX_EMPTY = 1'b1;
    last = -100;
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, 1'b0, 8'(8'h41 + i), rd, c);
      e.d   = 8'(8'h41 + i);
      e.cyc = (c + 2 > last + 3) ? c + 2 : last + 3;
      last  = e.cyc;
      tx_exp.push_back(e);
    end
    for (int k = 0; k < 40 && tx_got.size() < 3; k++) tick();
    while (tx_exp.size() != 0) begin
      e = tx_exp.pop_front();
      vectors++;
      if (tx_got.size() == 0) begin
        miscompares++; $display("FAIL tx_burst_missing: got none expected %02h", e.d);
      end else begin
        g = tx_got.pop_front();
        if (g.d !== e.d || g.cyc != e.cyc) begin
          miscompares++;
          $display("FAIL tx_burst: got %02h@%0d expected %02h@%0d", g.d, g.cyc, e.d, e.cyc);
        end
      end
    end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] rd;
    int c;
    ev_t e, g;
    U_TX_EMPTY = 1'b0;
    repeat (4) tick();
    tx_got.delete(); tx_exp.delete();
    for (int i = 0; i < 17; i++) bus(1'b1, 1'b0, 8'(8'h60 + i), rd, c);
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h20) begin
      miscompares++; $display("FAIL tx_ovf_set: got %02h expected 20", rd);
    end
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++; $display("FAIL tx_ovf_clear: got %02h expected 00", rd);
    end
    // Write into the full FIFO in the same cycle the FSM pops it.
    U_TX_EMPTY = 1'b1;
    bus(1'b1, 1'b0, 8'h70, rd, c);
    for (int j = 0; j < 17; j++) begin
      e.d   = (j < 16) ? 8'(8'h60 + j) : 8'h70;
      e.cyc = c + 1 + 3 * j;
      tx_exp.push_back(e);
    end
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++; $display("FAIL tx_full_pushpop: got %02h expected 00", rd);
    end
    for (int k = 0; k < 80 && tx_got.size() < 17; k++) tick();
    while (tx_exp.size() != 0) begin
      e = tx_exp.pop_front();
      vectors++;
      if (tx_got.size() == 0) begin
        miscompares++; $display("FAIL tx_drain_missing: got none expected %02h", e.d);
      end else begin
        g = tx_got.pop_front();
        if (g.d !== e.d || g.cyc != e.cyc) begin
          miscompares++;
          $display("FAIL tx_drain: got %02h@%0d expected %02h@%0d", g.d, g.cyc, e.d, e.cyc);
        end
      end
    end
    repeat (6) tick();
    vectors++;
    if (tx_got.size() != 0) begin
      miscompares++; $display("FAIL tx_drain_extra: got %0d extra expected 0", tx_got.size());
    end
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h12) begin
      miscompares++; $display("FAIL tx_drained_status: got %02h expected 12", rd);
    end
  endtask

  task automatic test_rx_fill();
    logic [7:0] rd, ex;
    int c, n;
    bit found;
    U_TX_EMPTY = 1'b1;
    rx_got_cyc.delete(); rx_exp.delete();
    for (int i = 0; i < 17; i++) begin
      rx_src.push_back(8'(i)); rx_exp.push_back(8'(i));
    end
    rx_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 150 && !found; k++) begin
      bus(1'b0, 1'b1, 8'h00, rd, c);
      if (rd[3]) found = 1'b1;
    end
    vectors++;
    if (!found || rd !== 8'h0B) begin
      miscompares++; $display("FAIL rx_fill_full: got %02h expected 0b", rd);
    end
    n = rx_got_cyc.size();
    repeat (10) tick();
    vectors++;
    if (rx_got_cyc.size() != n || rx_src.size() != 1) begin
      miscompares++;
      $display("FAIL rx_backpressure: got %0d reads %0d left expected %0d reads 1 left",
               rx_got_cyc.size(), rx_src.size(), n);
    end
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h1B) begin
      miscompares++; $display("FAIL rx_full_idle_status: got %02h expected 1b", rd);
    end
    ex = rx_exp.pop_front();
    bus(1'b0, 1'b0, 8'h00, rd, c);
    vectors++;
    if (rd !== ex) begin
      miscompares++; $display("FAIL rx_first_read: got %02h expected %02h", rd, ex);
    end
    repeat (3) tick();
    vectors++;
    if (rx_src.size() != 0 || rx_got_cyc.size() == 0 || rx_got_cyc[$] != c + 2) begin
      miscompares++;
      $display("FAIL rx_refill: got %0d left last=%0d expected 0 left last=%0d",
               rx_src.size(), (rx_got_cyc.size() != 0) ? rx_got_cyc[$] : -1, c + 2);
    end
    while (rx_exp.size() != 0) begin
      ex = rx_exp.pop_front();
      bus(1'b0, 1'b0, 8'h00, rd, c);
      vectors++;
      if (rd !== ex) begin
        miscompares++; $display("FAIL rx_data: got %02h expected %02h", rd, ex);
      end
    end
    rx_en = 1'b0;
  endtask

  task automatic test_priority();
    logic [7:0] rd;
    int c, k;
    U_TX_EMPTY = 1'b0;
    bus(1'b1, 1'b0, 8'h55, rd, c);
    repeat (2) tick();
    tx_got.delete(); rx_got_cyc.delete();
    rx_src.push_back(8'hA5); rx_en = 1'b1; U_TX_EMPTY = 1'b1;
    k = cyc;
    repeat (8) tick();
    vectors++;
    if (rx_got_cyc.size() != 1 || rx_got_cyc[0] != k + 1) begin
      miscompares++;
      $display("FAIL prio_rx_first: got %0d reads first@%0d expected 1 read @%0d",
               rx_got_cyc.size(), (rx_got_cyc.size() != 0) ? rx_got_cyc[0] : -1, k + 1);
    end
    vectors++;
    if (tx_got.size() != 1 || tx_got[0].cyc != k + 4 || tx_got[0].d !== 8'h55) begin
      miscompares++;
      $display("FAIL prio_tx_second: got %0d writes expected 55@%0d", tx_got.size(), k + 4);
    end
    @(negedge CLK);
    vectors++;
    if (CPU_DO !== 8'h00) begin
      miscompares++; $display("FAIL cs_low_do: got %02h expected 00", CPU_DO);
    end
    tick();
    bus(1'b0, 1'b0, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'hA5) begin
      miscompares++; $display("FAIL prio_rx_data: got %02h expected a5", rd);
    end
    rx_en = 1'b0;
  endtask

  task automatic test_edges();
    logic [7:0] rd;
    int c;
    U_BREAK = 1'b1;
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h16) begin
      miscompares++; $display("FAIL break_status: got %02h expected 16", rd);
    end
    U_BREAK = 1'b0;
    bus(1'b0, 1'b0, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++; $display("FAIL empty_read: got %02h expected 00", rd);
    end
    bus(1'b0, 1'b1, 8'h00, rd, c);
    vectors++;
    if (rd !== 8'h12) begin
      miscompares++; $display("FAIL empty_read_status: got %02h expected 12", rd);
    end
  endtask

  initial begin
    RESET = 1'b1; CPU_CS = 1'b0; CPU_WE = 1'b0; CPU_ADDR = 1'b0; CPU_DI = 8'h00;
    U_TX_EMPTY = 1'b1; U_BREAK = 1'b0;
    test_reset();
    test_tx_burst();
    test_tx_overflow();
    test_rx_fill();
    test_priority();
    test_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
